// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: fetch request/response, core instruction and redirect signals of the fetch front-end.
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [31:0]              imem_req_addr;
    logic                     imem_rsp_valid;
    logic [31:0]              imem_rsp_data;
    logic                     inst_valid;
    logic                     inst_ready;
    logic [31:0]              inst_data;
    logic [31:0]              inst_pc;
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic [$clog2(DEPTH):0]   queue_count;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, queue_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, queue_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetch with a credit-limited prefetch FIFO and redirect flush.
// Defining IFQ_BYPASS_EN forwards a response straight to the core when the queue is empty.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                clk,
    input logic                reset,
    inst_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = AW + 1;

    logic [31:0]   fetch_pc, rsp_pc, target;
    logic [W-1:0]  count, outstanding, drop_cnt;
    logic [W:0]    credit;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [63:0]   mem [DEPTH];
    logic          empty, req_fire, rsp_take, byp, pop, pop_fifo, push;

    always_comb begin
        target             = bus.redirect_pc & 32'hFFFF_FFFC;
        empty              = count == '0;
        // every issued request already owns a FIFO slot, so responses never overflow
        credit             = (W+1)'(count) + (W+1)'(outstanding) + (W+1)'(drop_cnt);
        bus.imem_req_valid = !reset && credit < (W+1)'(DEPTH) && !bus.redirect_valid;
        bus.imem_req_addr  = fetch_pc;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        rsp_take           = bus.imem_rsp_valid && drop_cnt == '0;
`ifdef IFQ_BYPASS_EN
        byp                = rsp_take && empty;
`else
        byp                = 1'b0;
`endif
        bus.inst_valid     = !empty || byp;
        bus.inst_data      = byp ? bus.imem_rsp_data : empty ? 32'h0 : mem[rd_ptr][31:0];
        bus.inst_pc        = byp ? rsp_pc : empty ? 32'h0 : mem[rd_ptr][63:32];
        pop                = bus.inst_valid && bus.inst_ready;
        pop_fifo           = pop && !empty;
        push               = rsp_take && !(byp && bus.inst_ready);
        bus.queue_count    = count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc    <= target;
            rsp_pc      <= target;
            count       <= '0;
            outstanding <= '0;
            // a response landing this cycle is already accounted for and needs no drop credit
            drop_cnt    <= drop_cnt + outstanding - W'(bus.imem_rsp_valid);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_take) rsp_pc <= rsp_pc + 32'd4;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop_fifo) rd_ptr <= rd_ptr + AW'(1);
            count       <= count + W'(push) - W'(pop_fifo);
            outstanding <= outstanding + W'(req_fire) - W'(rsp_take);
            drop_cnt    <= drop_cnt - W'(bus.imem_rsp_valid && !rsp_take);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.redirect_valid) mem[wr_ptr] <= {rsp_pc, bus.imem_rsp_data};
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: memory model plus scoreboard of expected {pc, data} for the fetch queue.
module tb_inst_fetch_queue;
`ifdef IFQ_BYPASS_EN
    localparam int RLAT = 2, T1_POPS = 11;
`else
    localparam int RLAT = 3, T1_POPS = 10;
`endif
    typedef struct { logic [31:0] addr; int due; } pend_t;

    logic        clk = 1'b0, reset = 1'b1;
    int          n_chk = 0, n_pass = 0, cyc = 0, lat = 1, n_req = 0, n_pop = 0;
    logic [31:0] exp_addr = 32'h0, held = 32'h0;
    bit          hold = 1'b0, last_vld = 1'b0, redir_vld = 1'b0;
    pend_t       pend[$];
    logic [63:0] sb[$];
    logic [31:0] pops[$];

    inst_fetch_queue_if #(.DEPTH(4)) bus();
    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ (a >> 2);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // one cycle: drive memory response, settle, score handshakes, advance to next negedge
    task automatic step();
        logic [63:0] e;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mdata(pend[0].addr);
            void'(pend.pop_front());
        end
        #1;
        last_vld = bus.inst_valid;
        if (hold && bus.imem_req_valid) check("addr_hold", 64'(bus.imem_req_addr), 64'(held));
        hold = bus.imem_req_valid && !bus.imem_req_ready;
        held = bus.imem_req_addr;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", 64'(bus.imem_req_addr), 64'(exp_addr));
            pend.push_back('{bus.imem_req_addr, cyc + lat});
            sb.push_back({exp_addr, mdata(exp_addr)});
            exp_addr += 32'd4;
            n_req++;
        end
        if (bus.inst_valid && bus.inst_ready) begin
            check("sb_avail", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("inst_pc", 64'(bus.inst_pc), 64'(e[63:32]));
                check("inst_data", 64'(bus.inst_data), 64'(e[31:0]));
            end
            pops.push_back(bus.inst_pc);
            n_pop++;
        end
        if (bus.redirect_valid) begin
            sb.delete();
            pops.delete();
            exp_addr = bus.redirect_pc & 32'hFFFF_FFFC;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] a, input bit chk_lat);
        int k;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = a;
        step();
        redir_vld          = last_vld;
        bus.redirect_valid = 1'b0;
        check("redir_flush", 64'(bus.queue_count), 64'd0);
        if (chk_lat) begin
            k = 0;
            do begin
                step();
                k++;
            end while (!last_vld && k < 10);
            check("redir_lat", 64'(k), 64'(RLAT));
        end
    endtask

    initial begin
        int p0, r0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        @(negedge clk);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_inst_data", 64'(bus.inst_data), 64'd0);
        check("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
        check("rst_count", 64'(bus.queue_count), 64'd0);
        reset = 1'b0;
        #1 check("first_req", 64'(bus.imem_req_valid), 64'd1);

        // sequential stream, 1-cycle memory
        p0 = n_pop;
        repeat (12) step();
        check("t1_pops", 64'(n_pop - p0), 64'(T1_POPS));
        check("t1_pc0", 64'(pops[0]), 64'h0);
        check("t1_pc1", 64'(pops[1]), 64'h4);
        check("t1_pc2", 64'(pops[2]), 64'h8);
        bus.imem_req_ready = 1'b0;
        repeat (3) step();
        bus.imem_req_ready = 1'b1;
        repeat (4) step();

        // core stalls: fetch stops once the queue is full
        r0 = n_req;
        bus.inst_ready = 1'b0;
        do_redirect(32'h1000, 1'b0);
        repeat (20) step();
        check("t2_reqs", 64'(n_req - r0), 64'd4);
        check("t2_count", 64'(bus.queue_count), 64'd4);
        check("t2_req_valid", 64'(bus.imem_req_valid), 64'd0);
        bus.inst_ready = 1'b1;
        p0 = n_pop;
        repeat (10) step();
        check("t2_pops", 64'(n_pop - p0), 64'd10);
        check("t2_resume", 64'(pops[0]), 64'h1000);

        // redirect with a response and a head handshake in the same cycle
        bus.inst_ready = 1'b0;
        step();
        bus.inst_ready = 1'b1;
        do_redirect(32'h200, 1'b1);
        check("t5_head_hs", 64'(redir_vld), 64'd1);
        check("t5_pc0", 64'(pops[0]), 64'h200);

        // unaligned target
        repeat (3) step();
        do_redirect(32'h103, 1'b1);
        check("t4_pc0", 64'(pops[0]), 64'h100);

        // address wrap
        repeat (3) step();
        do_redirect(32'hFFFF_FFFC, 1'b1);
        repeat (4) step();
        check("t6_pc0", 64'(pops[0]), 64'hFFFF_FFFC);
        check("t6_pc1", 64'(pops[1]), 64'h0);

        // 3-cycle memory, redirect with two requests in flight
        repeat (3) step();
        lat = 3;
        do_redirect(32'h300, 1'b0);
        step();
        step();
        do_redirect(32'h40, 1'b0);
        repeat (14) step();
        check("t3_npops", 64'(pops.size() >= 2), 64'd1);
        check("t3_pc0", 64'(pops[0]), 64'h40);
        check("t3_pc1", 64'(pops[1]), 64'h44);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction fetch front-end with a prefetch buffer, sitting directly upstream of the core's decode/execute datapath.
- Generates sequential word-aligned fetch addresses to instruction memory over a valid/ready request channel.
- Captures in-order responses into a FIFO tagged with their PC, and presents them to the core over a valid/ready channel.
- Core redirects (branch taken) flush the queue, discard in-flight responses and restart fetch at the target.

Parameters:
DEPTH, 4, FIFO entries and maximum total in-flight requests; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch byte address, bits[1:0] always 0
imem_rsp_valid  input  1  response data valid; in order, no backpressure
imem_rsp_data  input  32  instruction word
inst_valid  output  1  queue head valid
inst_ready  input  1  core consumes head
inst_data  output  32  head instruction
inst_pc  output  32  PC of head instruction
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  32  restart address; bits[1:0] ignored (forced 0)
queue_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, asynchronous, active-high:
  - fetch_pc = rsp_pc = RESET_PC.
  - count, outstanding and drop_cnt = 0; FIFO empty.
  - imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, queue_count = 0.
  - First request goes out in the first cycle after reset is released.
- Credit rule:
  - imem_req_valid = (count + outstanding + drop_cnt < DEPTH) && !redirect_valid.
  - Every response is therefore guaranteed a FIFO slot; the FIFO can never overflow.
- Request handshake (imem_req_valid && imem_req_ready):
  - outstanding += 1.
  - fetch_pc += 4, wrapping modulo 2^32.
  - imem_req_addr = fetch_pc.
  - While valid and not ready, the address is held stable unless a redirect occurs.
- Response handling:
  - If drop_cnt > 0: the response is discarded and drop_cnt -= 1.
  - Otherwise: push {rsp_pc, imem_rsp_data}, rsp_pc += 4, outstanding -= 1.
- Dequeue:
  - inst_valid = !empty; inst_data and inst_pc are the head entry, read combinationally from registers.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leaves count unchanged.
- Redirect (redirect_valid = 1 in cycle N):
  - A head handshake in cycle N counts as consumed.
  - At the end of N: FIFO emptied (count = 0).
  - drop_cnt <= drop_cnt + outstanding, counting any response arriving in N as already dropped.
  - outstanding <= 0.
  - fetch_pc <= rsp_pc <= {redirect_pc[31:2], 2'b00}.
  - No request is issued in N. The request for the target goes out in N+1.
  - With 1-cycle memory: target response in N+2, inst_valid in N+3 (non-bypass).
- Back-to-back redirects: each one accumulates into drop_cnt; the last target wins.
- Reset mid-operation: immediate return to the reset state. Responses arriving after reset for pre-reset requests are not tracked; memory is reset together with this block.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined: if the FIFO is empty, drop_cnt = 0 and a response arrives, then in the same cycle:
  - inst_valid = 1, inst_data = imem_rsp_data, inst_pc = rsp_pc.
  - If inst_ready = 1, the entry is consumed without being written to the FIFO. Otherwise it is pushed as normal.
- Redirect latency with 1-cycle memory drops to N+2.
- When undefined: the output is always driven from FIFO registers, with no combinational path from imem_rsp_* to inst_*.

Test Plan:
1. Reset, memory always ready with 1-cycle latency, inst_ready = 1 → requests to 0x0, 0x4, 0x8, …; inst_pc sequence 0x0, 0x4, 0x8 with matching data.
2. inst_ready = 0 for 20 cycles, DEPTH = 4 → exactly 4 requests issued, queue_count = 4, imem_req_valid = 0. Releasing inst_ready resumes fetch in order with no lost or duplicated PC.
3. Memory with 3-cycle latency, redirect to 0x40 while 2 requests are in flight → 2 responses dropped; next inst_pc = 0x40, then 0x44.
4. redirect_pc = 0x103 → request address 0x100; inst_pc = 0x100.
5. Redirect in the same cycle as a response and a head handshake → both the response and the remaining queue are discarded; the handshaked instruction is counted once; the next inst_pc is the target.
6. fetch_pc starting at 0xFFFF_FFFC → the next request address wraps to 0x0000_0000.
